// File: rtl/tx_seq_pkg.sv
// Shared types for the transmit pulse sequencer.
//   tx_state_e : sequencer control states
//   FAULT_*    : codes reported on otxFaultCode
package tx_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    ARMED = 3'd2,
    FIRE  = 3'd3,
    FAULT = 3'd4
  } tx_state_e;

  localparam logic [1:0] FAULT_NONE     = 2'd0;
  localparam logic [1:0] FAULT_CHARGE   = 2'd1;
  localparam logic [1:0] FAULT_OVERLAP  = 2'd2;
  localparam logic [1:0] FAULT_WATCHDOG = 2'd3;

endpackage

// File: rtl/tx_channel_pulse.sv
// One transducer channel: window comparator, registered drive pin and a
// consecutive-high watchdog.
//   clk, rst  : transmit clock, asynchronous active-high reset
//   en        : channel enabled and sequencer firing
//   kill      : force the pin low on the next edge
//   phase     : latched phase delay (cycles)
//   charge    : latched charge time (cycles)
//   t         : firing time counter within the current pulse
//   win_end   : phase + charge, full width (no overflow)
//   out       : registered drive pin
//   wd_trip   : pin has been high for more than MAX_CHARGE cycles
module tx_channel_pulse #(
  parameter int PHASE_W    = 16,
  parameter int CHARGE_W   = 9,
  parameter int MAX_CHARGE = 400
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                kill,
  input  logic [PHASE_W-1:0]  phase,
  input  logic [CHARGE_W-1:0] charge,
  input  logic [PHASE_W:0]    t,
  output logic [PHASE_W:0]    win_end,
  output logic                out,
  output logic                wd_trip
);

  localparam int              WD_W     = $clog2(MAX_CHARGE + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_CHARGE);
  localparam logic [WD_W-1:0] WD_ONE   = WD_W'(1);

  logic            win;
  logic            out_q, out_d;
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;

  assign win_end = {1'b0, phase} + {{(PHASE_W + 1 - CHARGE_W){1'b0}}, charge};
  assign win     = en && ({1'b0, phase} <= t) && (t < win_end);

  // wd_cnt_q holds how many completed cycles the pin has already been high,
  // so it reaches MAX_CHARGE during the first over-limit cycle.
  always_comb begin
    out_d    = win && !kill;
    wd_cnt_d = '0;
    if (out_q) begin
      wd_cnt_d = (wd_cnt_q == WD_LIMIT) ? wd_cnt_q : wd_cnt_q + WD_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= 1'b0;
      wd_cnt_q <= '0;
    end else begin
      out_q    <= out_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign out     = out_q;
  assign wd_trip = out_q && (wd_cnt_q == WD_LIMIT);

endmodule

// File: rtl/tx_pulse_sequencer.sv
// N-channel phased pulse sequencer. Latches settings on arm, validates them,
// waits for a trigger rising edge and fires a burst of phased pulses, with
// charge, overlap, timeout and watchdog protection.
//   txCLK, txRST         : clock, asynchronous active-high reset
//   itxArm               : latch + validate settings (IDLE only)
//   itxTrigger           : trigger level, rising edge fires
//   itxAbort             : stop immediately (not in FAULT)
//   itxClearFault        : leave FAULT
//   itxPhaseDelay        : per-channel phase, channel i at [i*PHASE_W +: PHASE_W]
//   itxChargeTime        : pulse width
//   itxMask              : channel enables
//   itxBurstCount        : pulses per trigger (0 acts as 1)
//   itxPulsePeriod       : cycles between pulse starts
//   otxTransducerOutput  : registered drive pins
//   otxArmed/Busy/Done/Fault/FaultCode : registered status
module tx_pulse_sequencer
  import tx_seq_pkg::*;
#(
  parameter int NCH         = 8,
  parameter int PHASE_W     = 16,
  parameter int CHARGE_W    = 9,
  parameter int MAX_CHARGE  = 400,
  parameter int BURST_W     = 8,
  parameter int ARM_TIMEOUT = 2**24 - 1
) (
  input  logic                   txCLK,
  input  logic                   txRST,
  input  logic                   itxArm,
  input  logic                   itxTrigger,
  input  logic                   itxAbort,
  input  logic                   itxClearFault,
  input  logic [NCH*PHASE_W-1:0] itxPhaseDelay,
  input  logic [CHARGE_W-1:0]    itxChargeTime,
  input  logic [NCH-1:0]         itxMask,
  input  logic [BURST_W-1:0]     itxBurstCount,
  input  logic [PHASE_W:0]       itxPulsePeriod,
  output logic [NCH-1:0]         otxTransducerOutput,
  output logic                   otxArmed,
  output logic                   otxBusy,
  output logic                   otxDone,
  output logic                   otxFault,
  output logic [1:0]             otxFaultCode
);

  localparam int                 TO_W    = $clog2(ARM_TIMEOUT + 1);
  localparam logic [TO_W-1:0]    TO_LAST = TO_W'(ARM_TIMEOUT - 1);
  localparam logic [TO_W-1:0]    TO_ONE  = TO_W'(1);
  localparam logic [PHASE_W:0]   T_ONE   = (PHASE_W + 1)'(1);
  localparam logic [BURST_W-1:0] B_ONE   = BURST_W'(1);

  tx_state_e            state_q, state_d;
  logic                 trig_q, trig_d, trig_prev_q, trig_prev_d;
  logic [PHASE_W:0]     t_q, t_d;
  logic [BURST_W-1:0]   p_q, p_d;
  logic [TO_W-1:0]      to_q, to_d;
  logic [PHASE_W:0]     max_end_q, max_end_d;
  logic [1:0]           code_q, code_d;
  logic                 armed_q, armed_d, busy_q, busy_d, done_q, done_d;
  logic                 fault_q, fault_d;
  logic [1:0]           fcode_q, fcode_d;

  logic [NCH*PHASE_W-1:0] phase_q;
  logic [CHARGE_W-1:0]    charge_q;
  logic [NCH-1:0]         mask_q;
  logic [BURST_W-1:0]     burst_q;
  logic [PHASE_W:0]       period_q;

  logic [NCH-1:0]       ch_trip;
  logic [PHASE_W:0]     ch_end [NCH];
  logic [PHASE_W:0]     max_end_c;
  logic [BURST_W-1:0]   burst_last;
  logic                 fire, kill, wd_any, trig_edge, bad_charge, overlap;

  // Settings are only meaningful once latched, so they carry no reset.
  always_ff @(posedge txCLK) begin
    if (state_q == IDLE && itxArm) begin
      phase_q  <= itxPhaseDelay;
      charge_q <= itxChargeTime;
      mask_q   <= itxMask;
      burst_q  <= itxBurstCount;
      period_q <= itxPulsePeriod;
    end
  end

  assign fire   = (state_q == FIRE);
  assign wd_any = |ch_trip;
  assign kill   = wd_any || (state_q == FAULT);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    tx_channel_pulse #(
      .PHASE_W    (PHASE_W),
      .CHARGE_W   (CHARGE_W),
      .MAX_CHARGE (MAX_CHARGE)
    ) u_ch (
      .clk     (txCLK),
      .rst     (txRST),
      .en      (mask_q[i] && fire),
      .kill    (kill),
      .phase   (phase_q[i*PHASE_W +: PHASE_W]),
      .charge  (charge_q),
      .t       (t_q),
      .win_end (ch_end[i]),
      .out     (otxTransducerOutput[i]),
      .wd_trip (ch_trip[i])
    );
  end

  always_comb begin
    max_end_c = '0;
    for (int i = 0; i < NCH; i++) begin
      if (mask_q[i] && (ch_end[i] > max_end_c)) max_end_c = ch_end[i];
    end
  end

  // Trigger goes through two flops: the edge is seen one cycle after the
  // sampling edge, which puts a zero-phase pulse two edges after the trigger.
  assign trig_edge  = trig_q && !trig_prev_q;
  assign bad_charge = (charge_q == '0) || (charge_q > CHARGE_W'(MAX_CHARGE)) ||
                      (mask_q == '0);
  assign overlap    = (burst_q > B_ONE) && (period_q <= max_end_c);
  assign burst_last = (burst_q == '0) ? '0 : burst_q - B_ONE;

  always_comb begin
    state_d     = state_q;
    trig_d      = itxTrigger;
    trig_prev_d = trig_q;
    t_d         = t_q;
    p_d         = p_q;
    to_d        = to_q;
    max_end_d   = max_end_q;
    code_d      = code_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: if (itxArm) state_d = CHECK;
      CHECK: begin
        max_end_d = max_end_c;
        if (bad_charge) begin
          state_d = FAULT;
          code_d  = FAULT_CHARGE;
        end else if (overlap) begin
          state_d = FAULT;
          code_d  = FAULT_OVERLAP;
        end else begin
          state_d = ARMED;
          to_d    = '0;
        end
      end
      ARMED: begin
        if (trig_edge) begin
          state_d = FIRE;
          t_d     = '0;
          p_d     = '0;
        end else if (to_q == TO_LAST) begin
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_ONE;
        end
      end
      FIRE: begin
        if ((p_q == burst_last) && (t_q == max_end_q - T_ONE)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if ((t_q == period_q - T_ONE) && (p_q < burst_last)) begin
          t_d = '0;
          p_d = p_q + B_ONE;
        end else begin
          t_d = t_q + T_ONE;
        end
      end
      FAULT: begin
        if (itxClearFault) begin
          state_d = IDLE;
          code_d  = FAULT_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides normal sequencing; the watchdog overrides everything.
    if (itxAbort && state_q != FAULT) begin
      state_d = IDLE;
      done_d  = 1'b0;
    end
    if (wd_any && state_q != FAULT) begin
      state_d = FAULT;
      code_d  = FAULT_WATCHDOG;
      done_d  = 1'b0;
    end
    armed_d = (state_q == ARMED);
    busy_d  = (state_q == CHECK) || (state_q == FIRE);
    fault_d = (state_q == FAULT);
    fcode_d = code_q;
  end

  always_ff @(posedge txCLK or posedge txRST) begin
    if (txRST) begin
      state_q     <= IDLE;
      trig_q      <= 1'b0;
      trig_prev_q <= 1'b0;
      t_q         <= '0;
      p_q         <= '0;
      to_q        <= '0;
      max_end_q   <= '0;
      code_q      <= FAULT_NONE;
      armed_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      fcode_q     <= FAULT_NONE;
    end else begin
      state_q     <= state_d;
      trig_q      <= trig_d;
      trig_prev_q <= trig_prev_d;
      t_q         <= t_d;
      p_q         <= p_d;
      to_q        <= to_d;
      max_end_q   <= max_end_d;
      code_q      <= code_d;
      armed_q     <= armed_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      fcode_q     <= fcode_d;
    end
  end

  assign otxArmed     = armed_q;
  assign otxBusy      = busy_q;
  assign otxDone      = done_q;
  assign otxFault     = fault_q;
  assign otxFaultCode = fcode_q;

endmodule

// File: tb/tb_tx_pulse_sequencer.sv
// Self-checking bench for tx_pulse_sequencer with a timeline-level reference
// model of the expected pulse trains.
module tb_tx_pulse_sequencer;

  localparam int NCH         = 8;
  localparam int PHASE_W     = 16;
  localparam int CHARGE_W    = 9;
  localparam int MAX_CHARGE  = 400;
  localparam int BURST_W     = 8;
  localparam int ARM_TIMEOUT = 100;

  logic                   txCLK = 1'b0;
  logic                   txRST;
  logic                   itxArm, itxTrigger, itxAbort, itxClearFault;
  logic [NCH*PHASE_W-1:0] itxPhaseDelay;
  logic [CHARGE_W-1:0]    itxChargeTime;
  logic [NCH-1:0]         itxMask;
  logic [BURST_W-1:0]     itxBurstCount;
  logic [PHASE_W:0]       itxPulsePeriod;
  logic [NCH-1:0]         otxTransducerOutput;
  logic                   otxArmed, otxBusy, otxDone, otxFault;
  logic [1:0]             otxFaultCode;

  tx_pulse_sequencer #(
    .NCH(NCH), .PHASE_W(PHASE_W), .CHARGE_W(CHARGE_W), .MAX_CHARGE(MAX_CHARGE),
    .BURST_W(BURST_W), .ARM_TIMEOUT(ARM_TIMEOUT)
  ) dut (
    .txCLK(txCLK), .txRST(txRST), .itxArm(itxArm), .itxTrigger(itxTrigger),
    .itxAbort(itxAbort), .itxClearFault(itxClearFault),
    .itxPhaseDelay(itxPhaseDelay), .itxChargeTime(itxChargeTime),
    .itxMask(itxMask), .itxBurstCount(itxBurstCount),
    .itxPulsePeriod(itxPulsePeriod),
    .otxTransducerOutput(otxTransducerOutput), .otxArmed(otxArmed),
    .otxBusy(otxBusy), .otxDone(otxDone), .otxFault(otxFault),
    .otxFaultCode(otxFaultCode)
  );

  always #5 txCLK = ~txCLK;

  int vectors = 0;
  int miscompares = 0;

  int s_ph[NCH];
  int s_charge, s_mask, s_burst, s_period;

  int fc_charge[6] = '{0, 401, 20, 20, 20, 20};
  int fc_mask[6]   = '{255, 255, 0, 255, 255, 255};
  int fc_burst[6]  = '{1, 1, 1, 2, 2, 0};
  int fc_period[6] = '{0, 0, 0, 90, 91, 5};
  int fc_code[6]   = '{1, 1, 1, 2, 0, 0};

  task automatic tick();
    @(posedge txCLK);
    #1;
  endtask

  task automatic drive_settings();
    for (int i = 0; i < NCH; i++) itxPhaseDelay[i*PHASE_W +: PHASE_W] = PHASE_W'(s_ph[i]);
    itxChargeTime  = CHARGE_W'(s_charge);
    itxMask        = NCH'(s_mask);
    itxBurstCount  = BURST_W'(s_burst);
    itxPulsePeriod = (PHASE_W + 1)'(s_period);
  endtask

  task automatic stepped_settings(int charge, int mask, int burst, int period);
    for (int i = 0; i < NCH; i++) s_ph[i] = 10 * i;
    s_charge = charge; s_mask = mask; s_burst = burst; s_period = period;
  endtask

  function automatic int burst_eff();
    return (s_burst == 0) ? 1 : s_burst;
  endfunction

  function automatic int model_max_end();
    int m = 0;
    for (int i = 0; i < NCH; i++)
      if (((s_mask >> i) & 1) != 0 && s_ph[i] + s_charge > m) m = s_ph[i] + s_charge;
    return m;
  endfunction

  // Cycle n counts edges after the trigger-sampling edge E.
  function automatic logic [NCH-1:0] model_out(int n);
    logic [NCH-1:0] r = '0;
    for (int i = 0; i < NCH; i++) begin
      if (((s_mask >> i) & 1) != 0) begin
        for (int k = 0; k < burst_eff(); k++) begin
          int s;
          s = s_ph[i] + 2 + k * s_period;
          if (n >= s && n < s + s_charge) r[i] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  function automatic int model_done_n();
    return 1 + (burst_eff() - 1) * s_period + model_max_end();
  endfunction

  task automatic arm_pulse();
    drive_settings();
    itxArm = 1'b1;
    tick();
    itxArm = 1'b0;
  endtask

  task automatic test_fire(string tag);
    int nd, nmax;
    logic [NCH-1:0] exp_o;
    arm_pulse();
    tick();
    tick();
    vectors++;
    if (otxArmed !== 1'b1) begin
      miscompares++;
      $display("FAIL %s armed: got %b want 1", tag, otxArmed);
    end
    itxTrigger = 1'b1;
    nd = model_done_n();
    nmax = (nd + 3 > 30) ? nd + 3 : 30;
    for (int n = 0; n <= nmax; n++) begin
      tick();
      exp_o = model_out(n);
      vectors++;
      if (otxTransducerOutput !== exp_o) begin
        miscompares++;
        $display("FAIL %s out n=%0d: got %h want %h", tag, n, otxTransducerOutput, exp_o);
      end
      vectors++;
      if (otxDone !== 1'(n == nd)) begin
        miscompares++;
        $display("FAIL %s done n=%0d: got %b want %b", tag, n, otxDone, n == nd);
      end
      if (n == 3) itxTrigger = 1'b0;
      if (n == 20) itxTrigger = 1'b1;
      if (n == 25) itxTrigger = 1'b0;
    end
    vectors++;
    if (otxBusy !== 1'b0 || otxArmed !== 1'b0 || otxFault !== 1'b0) begin
      miscompares++;
      $display("FAIL %s idle: busy %b armed %b fault %b want 000", tag, otxBusy, otxArmed, otxFault);
    end
  endtask

  task automatic test_reset();
    txRST = 1'b1;
    itxArm = 0; itxTrigger = 0; itxAbort = 0; itxClearFault = 0;
    stepped_settings(20, 255, 1, 0);
    drive_settings();
    tick(); tick(); tick();
    vectors++; if (otxTransducerOutput !== '0) begin miscompares++; $display("FAIL reset out: got %h want 0", otxTransducerOutput); end
    vectors++; if (otxArmed !== 1'b0) begin miscompares++; $display("FAIL reset armed: got %b want 0", otxArmed); end
    vectors++; if (otxBusy !== 1'b0) begin miscompares++; $display("FAIL reset busy: got %b want 0", otxBusy); end
    vectors++; if (otxDone !== 1'b0) begin miscompares++; $display("FAIL reset done: got %b want 0", otxDone); end
    vectors++; if (otxFault !== 1'b0) begin miscompares++; $display("FAIL reset fault: got %b want 0", otxFault); end
    vectors++; if (otxFaultCode !== 2'd0) begin miscompares++; $display("FAIL reset code: got %0d want 0", otxFaultCode); end
    txRST = 1'b0;
    tick();
  endtask

  task automatic test_single_burst();
    stepped_settings(20, 255, 1, 0);
    test_fire("single");
  endtask

  task automatic test_multi_burst();
    stepped_settings(20, 255, 3, 120);
    test_fire("burst3");
  endtask

  task automatic test_mask();
    stepped_settings(20, 8'h05, 2, 95);
    test_fire("mask05");
  endtask

  task automatic test_charge_limit();
    for (int i = 0; i < NCH; i++) s_ph[i] = 0;
    s_charge = MAX_CHARGE; s_mask = 1; s_burst = 1; s_period = 0;
    test_fire("charge_max");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NCH; i++) s_ph[i] = int'($urandom_range(0, 60));
      s_charge = int'($urandom_range(1, 30));
      s_mask   = int'($urandom_range(1, 255));
      s_burst  = int'($urandom_range(0, 3));
      if (s_burst > 1) s_period = model_max_end() + int'($urandom_range(1, 15));
      else             s_period = int'($urandom_range(0, 200));
      test_fire("random");
    end
  endtask

  task automatic test_faults();
    for (int c = 0; c < 6; c++) begin
      stepped_settings(fc_charge[c], fc_mask[c], fc_burst[c], fc_period[c]);
      arm_pulse();
      tick();
      tick();
      if (fc_code[c] == 0) begin
        vectors++;
        if (otxArmed !== 1'b1 || otxFault !== 1'b0 || otxFaultCode !== 2'd0) begin
          miscompares++;
          $display("FAIL check_ok case %0d: armed %b fault %b code %0d want 1 0 0", c, otxArmed, otxFault, otxFaultCode);
        end
        itxAbort = 1'b1;
        tick();
        itxAbort = 1'b0;
        tick();
        tick();
        vectors++;
        if (otxArmed !== 1'b0) begin miscompares++; $display("FAIL abort_armed case %0d: got %b want 0", c, otxArmed); end
      end else begin
        vectors++;
        if (otxFault !== 1'b1 || otxArmed !== 1'b0) begin
          miscompares++;
          $display("FAIL fault case %0d: fault %b armed %b want 1 0", c, otxFault, otxArmed);
        end
        vectors++;
        if (otxFaultCode !== 2'(fc_code[c])) begin
          miscompares++;
          $display("FAIL fault_code case %0d: got %0d want %0d", c, otxFaultCode, fc_code[c]);
        end
        stepped_settings(20, 255, 1, 0);
        arm_pulse();
        itxTrigger = 1'b1;
        tick(); tick(); tick();
        itxTrigger = 1'b0;
        vectors++;
        if (otxFault !== 1'b1 || otxArmed !== 1'b0 || otxFaultCode !== 2'(fc_code[c]) || otxTransducerOutput !== '0) begin
          miscompares++;
          $display("FAIL fault_hold case %0d: fault %b armed %b code %0d out %h", c, otxFault, otxArmed, otxFaultCode, otxTransducerOutput);
        end
        itxClearFault = 1'b1;
        tick();
        itxClearFault = 1'b0;
        tick();
        tick();
        vectors++;
        if (otxFault !== 1'b0 || otxFaultCode !== 2'd0) begin
          miscompares++;
          $display("FAIL clear case %0d: fault %b code %0d want 0 0", c, otxFault, otxFaultCode);
        end
      end
    end
  endtask

  task automatic test_abort();
    bit done_seen = 0;
    stepped_settings(20, 255, 1, 0);
    arm_pulse();
    tick();
    tick();
    itxTrigger = 1'b1;
    for (int n = 0; n <= 15; n++) tick();
    itxAbort = 1'b1;
    tick();
    itxAbort = 1'b0;
    itxTrigger = 1'b0;
    tick();
    vectors++;
    if (otxTransducerOutput !== '0 || otxBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort: out %h busy %b want 0 0", otxTransducerOutput, otxBusy);
    end
    for (int n = 0; n < 100; n++) begin
      tick();
      if (otxDone === 1'b1 || otxTransducerOutput !== '0) done_seen = 1;
    end
    vectors++;
    if (done_seen) begin miscompares++; $display("FAIL abort_quiet: activity %b want 0", done_seen); end
    test_fire("rearm");
  endtask

  task automatic test_timeout();
    int hi = 0;
    bit seen = 0, dropped = 0;
    stepped_settings(20, 255, 1, 0);
    arm_pulse();
    for (int c = 0; c < 300 && !dropped; c++) begin
      tick();
      if (otxArmed === 1'b1) begin hi++; seen = 1; end
      else if (seen) dropped = 1;
    end
    vectors++;
    if (!dropped || hi != ARM_TIMEOUT) begin
      miscompares++;
      $display("FAIL timeout: armed for %0d cycles (dropped %b) want %0d", hi, dropped, ARM_TIMEOUT);
    end
    vectors++;
    if (otxFault !== 1'b0 || otxBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_state: fault %b busy %b want 0 0", otxFault, otxBusy);
    end
  endtask

  task automatic test_watchdog();
    int hi = 0;
    bit seen = 0, dropped = 0;
    force dut.g_ch[3].u_ch.win = 1'b1;
    for (int c = 0; c < 600 && !dropped; c++) begin
      tick();
      if (otxTransducerOutput[3] === 1'b1) begin hi++; seen = 1; end
      else if (seen) dropped = 1;
    end
    vectors++;
    if (!dropped || hi != MAX_CHARGE + 1) begin
      miscompares++;
      $display("FAIL watchdog_len: high %0d cycles (dropped %b) want %0d", hi, dropped, MAX_CHARGE + 1);
    end
    tick();
    tick();
    vectors++;
    if (otxFault !== 1'b1 || otxFaultCode !== 2'd3 || otxTransducerOutput !== '0) begin
      miscompares++;
      $display("FAIL watchdog: fault %b code %0d out %h want 1 3 0", otxFault, otxFaultCode, otxTransducerOutput);
    end
    release dut.g_ch[3].u_ch.win;
    tick();
    itxClearFault = 1'b1;
    tick();
    itxClearFault = 1'b0;
    tick();
    tick();
    vectors++;
    if (otxFault !== 1'b0 || otxFaultCode !== 2'd0 || otxTransducerOutput !== '0) begin
      miscompares++;
      $display("FAIL watchdog_clear: fault %b code %0d out %h want 0 0 0", otxFault, otxFaultCode, otxTransducerOutput);
    end
  endtask

  task automatic test_async_reset();
    stepped_settings(20, 255, 1, 0);
    arm_pulse();
    tick();
    tick();
    itxTrigger = 1'b1;
    for (int n = 0; n <= 30; n++) tick();
    vectors++;
    if (otxTransducerOutput !== model_out(30)) begin
      miscompares++;
      $display("FAIL pre_reset out: got %h want %h", otxTransducerOutput, model_out(30));
    end
    #3;
    txRST = 1'b1;
    #1;
    vectors++;
    if (otxTransducerOutput !== '0 || otxBusy !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: out %h busy %b want 0 0", otxTransducerOutput, otxBusy);
    end
    itxTrigger = 1'b0;
    tick();
    txRST = 1'b0;
    tick();
    tick();
    vectors++;
    if (otxArmed !== 1'b0 || otxTransducerOutput !== '0) begin
      miscompares++;
      $display("FAIL post_reset: armed %b out %h want 0 0", otxArmed, otxTransducerOutput);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_mask();
    test_charge_limit();
    test_random();
    test_faults();
    test_abort();
    test_timeout();
    test_watchdog();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/tx_pulse_sequencer.md
# tx_pulse_sequencer

Parametrised N-channel phased pulse sequencer; next generation of the transmit output controller. Latches per-channel phase delays, a common charge time, a channel mask and a burst description on an arm command. On an external trigger edge it fires a burst of phased pulses on all enabled transducer channels. It sits between the PIO/RAM control logic and the transducer driver pins, and enforces charge-time, overlap and watchdog safety limits in hardware.

## Interface
- NCH, 8, number of transducer channels
- PHASE_W, 16, phase-delay width (cycles)
- CHARGE_W, 9, charge-time width (cycles)
- MAX_CHARGE, 400, largest legal charge time; also the watchdog limit
- BURST_W, 8, burst pulse-count width
- ARM_TIMEOUT, 2**24-1, cycles ARMED waits for a trigger before disarming
- txCLK  in  1  transmit clock; all logic on rising edge
- txRST  in  1  reset, asynchronous, active-high
- itxArm  in  1  one-cycle pulse; validate and latch settings (honoured in IDLE only)
- itxTrigger  in  1  external trigger level; the rising edge fires
- itxAbort  in  1  level; stops any activity immediately
- itxClearFault  in  1  one-cycle pulse; FAULT -> IDLE
- itxPhaseDelay  in  NCH*PHASE_W  channel i at [i*PHASE_W +: PHASE_W]
- itxChargeTime  in  CHARGE_W  pulse width (cycles)
- itxMask  in  NCH  1 = channel enabled
- itxBurstCount  in  BURST_W  pulses per trigger; 0 is treated as 1
- itxPulsePeriod  in  PHASE_W+1  cycles between pulse starts within a burst
- otxTransducerOutput  out  NCH  registered drive pins
- otxArmed  out  1  high in ARMED
- otxBusy  out  1  high in CHECK/FIRE
- otxDone  out  1  one-cycle pulse at burst completion
- otxFault  out  1  high in FAULT
- otxFaultCode  out  2  1 = bad charge, 2 = overlap, 3 = watchdog, 0 = none

## Operation
- All outputs reset to 0. After reset the block is in IDLE.
- State IDLE, on itxArm: latch all settings and go to CHECK.
- State CHECK (1 cycle):
  - Compute maxEnd = max over enabled channels of (phase + charge), in PHASE_W+1 bits, no overflow.
  - Fault 1 if charge == 0, or charge > MAX_CHARGE, or mask == 0.
  - Fault 2 if burst > 1 and period <= maxEnd.
  - Otherwise go to ARMED.
- State ARMED:
  - Trigger rising edge (registered previous sample) -> FIRE with t = 0 and pulse index p = 0.
  - After ARM_TIMEOUT cycles without a trigger -> IDLE (no fault).
- State FIRE:
  - Counter t increments each cycle.
  - Channel i is high when mask[i] and phase[i] <= t < phase[i] + charge.
  - When t == period-1 and p < burst-1: t <= 0, p++.
  - When p == burst-1 and t == maxEnd-1: otxDone pulse, go to IDLE.
  - Trigger edges during FIRE are ignored.
- Abort, in any state other than FAULT: outputs 0 on the next edge, go to IDLE, no done pulse.
- Watchdog: any output high for more than MAX_CHARGE consecutive cycles -> all outputs 0, FAULT code 3.
- FAULT: outputs forced 0; otxFaultCode is held. itxClearFault -> IDLE and code cleared. Arm and trigger are ignored while in FAULT.
- Simultaneous events, priority order: txRST > watchdog fault > itxAbort > done > timeout.

## Timing
- Trigger sampled high (previous sample low) at edge E. Then otxTransducerOutput[i] rises at edge E+2+phase[i] and stays high exactly charge cycles.
- Pulse k of a burst is offset by k*period.
- otxDone is high for the single cycle after edge E+2+(burst-1)*period+maxEnd-1.
- itxArm at edge A: otxArmed goes high at edge A+2, or otxFault goes high at A+2.
- Abort sampled at edge X: outputs and otxBusy are low after edge X+1.
- Settings inputs are don't-care except at the latching edge.

## Structure
- Package tx_seq_pkg holds:
  - state enum (IDLE, CHECK, ARMED, FIRE, FAULT)
  - fault-code constants
- Sub-module tx_channel_pulse, instantiated NCH times via generate. It contains the window comparator, the registered output and the per-channel watchdog counter, with a fault output.
- The top level holds the FSM, the t/p counters, the maxEnd reduction and the timeout counter.

## Test plan
- NCH=8, phases 0,10,…,70, charge 20, mask FF, burst 1, arm then trigger -> ch0 high for edges E+2..E+21, ch7 for E+72..E+91; done after E+91.
- Burst 3, period 120, same settings -> three pulse trains at offsets 0/120/240; a single done pulse at E+2+240+89.
- Charge 0 -> fault code 1. Charge 20 with phase max 70, burst 2, period 90 -> fault code 2. itxClearFault returns to IDLE with code 0.
- Abort raised mid-FIRE at t=15 -> all outputs 0 after the next edge; no done; a re-arm succeeds.
- Mask 0x05 -> only ch0 and ch2 toggle. A trigger during FIRE does not restart the burst. ARM_TIMEOUT=100 with no trigger -> otxArmed drops after 100 cycles.
- Force the internal window via override so output stays high for MAX_CHARGE+1 cycles -> fault code 3 and outputs 0. Assert txRST mid-FIRE -> all outputs 0 immediately (asynchronous).
